// File: rtl/fm_result_reader_if.sv
// Element stream leaving the result reader: valid/ready with a last marker.
interface fm_result_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/fm_result_reader.sv
// Feature-map result reader: fetches packed PARA_X*PARA_Y-lane words from the
// output RAM one at a time and serializes them lane 0 first onto a stream.
module fm_result_reader #(
    parameter int DATA_WIDTH      = 16,
    parameter int PARA_X          = 3,
    parameter int PARA_Y          = 3,
    parameter int READ_ADDR_WIDTH = 10,
    parameter int RAM_LATENCY     = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start_read,
    input  logic [READ_ADDR_WIDTH-1:0]              base_addr,
    input  logic [READ_ADDR_WIDTH-1:0]              word_count,
    output logic                                    ram_rd_en,
    output logic [READ_ADDR_WIDTH-1:0]              ram_rd_addr,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]     ram_rd_data,
    fm_result_reader_if.master                      out_if,
    output logic                                    busy,
    output logic                                    read_done
);
    localparam int NUM_LANES = PARA_X * PARA_Y;
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LAT_W     = 3;
    localparam int AW        = READ_ADDR_WIDTH;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e                                 state_q, state_d;
    logic [AW-1:0]                          addr_q, addr_d;
    logic [AW-1:0]                          cnt_q, cnt_d;
    logic [AW-1:0]                          widx_q, widx_d;
    logic [LANE_W-1:0]                      lane_q, lane_d;
    logic [LAT_W-1:0]                       lat_q, lat_d;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   buf_q, buf_d;

    logic xfer;
    logic last_word;

    assign xfer      = (state_q == SHIFT) && out_if.out_ready;
    assign last_word = (widx_q == cnt_q - AW'(1));

    // Outputs decode straight from registered state so reset clears them at once.
    assign ram_rd_en        = (state_q == FETCH);
    assign ram_rd_addr      = addr_q;
    assign busy             = (state_q != IDLE);
    assign read_done        = (state_q == DONE);
    assign out_if.out_valid = (state_q == SHIFT);
    assign out_if.out_data  = (state_q == SHIFT) ? buf_q[lane_q] : '0;
    assign out_if.out_last  = (state_q == SHIFT) && (lane_q == LANE_LAST) && last_word;

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            lane_q  <= '0;
            lat_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            lane_q  <= lane_d;
            lat_q   <= lat_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state: one word per FETCH/WAIT/SHIFT round, no prefetch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        lane_d  = lane_q;
        lat_d   = lat_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start_read) begin
                    cnt_d  = word_count;
                    widx_d = '0;
                    lane_d = '0;
                    if (word_count != '0) begin
                        // Address only moves when a read will follow, so it
                        // keeps showing the last fetched word otherwise.
                        addr_d  = base_addr;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                lat_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    buf_d   = ram_rd_data;
                    state_d = SHIFT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (lane_q == LANE_LAST) begin
                        lane_d = '0;
                        widx_d = widx_q + AW'(1);
                        if (last_word) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_fm_result_reader.sv
// Scoreboard bench for fm_result_reader: a latency-accurate RAM model, expected
// elements and addresses queued at stimulus time and popped as the DUT emits.
module tb_fm_result_reader;
    localparam int DW   = 16;
    localparam int NL   = 9;
    localparam int AW   = 10;
    localparam int LAT  = 2;
    localparam int WW   = NL * DW;
    localparam int BUDGET = 600;

    logic          clk;
    logic          rst;
    logic          start_read;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_count;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [WW-1:0] ram_rd_data;
    logic          busy;
    logic          read_done;

    fm_result_reader_if #(.DATA_WIDTH(DW)) ifc ();

    fm_result_reader #(
        .DATA_WIDTH(DW), .PARA_X(3), .PARA_Y(3),
        .READ_ADDR_WIDTH(AW), .RAM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .start_read(start_read), .base_addr(base_addr), .word_count(word_count),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .out_if(ifc.master),
        .busy(busy), .read_done(read_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // RAM model: data is only valid exactly LAT cycles after the strobe.
    logic [WW-1:0] mem [1024];
    logic [LAT-1:0] en_p;
    logic [AW-1:0]  a_p [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            en_p[i] <= en_p[i-1];
            a_p[i]  <= a_p[i-1];
        end
        en_p[0] <= ram_rd_en;
        a_p[0]  <= ram_rd_addr;
    end

    assign ram_rd_data = en_p[LAT-1] ? mem[a_p[LAT-1]] : {NL{16'hBAD0}};

    // Downstream ready: constant 1, or the 1,0,0,1 stall pattern.
    bit       rdy_mode = 1'b0;
    int       ph = 0;
    logic [3:0] pat = 4'b1001;

    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            ifc.out_ready = pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            ifc.out_ready = 1'b1;
        end
    end

    // Scoreboards and monitor.
    logic [DW:0]   sb [$];
    logic [AW-1:0] aq [$];
    int n_xfer = 0;
    int n_last = 0;
    int n_en   = 0;
    bit          stall_q = 1'b0;
    logic [DW:0] stall_v;

    always @(negedge clk) begin
        if (rst) begin
            if (ram_rd_en) begin
                n_en++;
                chk("aq_avail", 32'(aq.size() != 0), 32'd1);
                if (aq.size() != 0) chk("rd_addr", 32'(ram_rd_addr), 32'(aq.pop_front()));
            end
            if (stall_q) begin
                chk("stall_valid", 32'(ifc.out_valid), 32'd1);
                chk("stall_data", 32'({ifc.out_last, ifc.out_data}), 32'(stall_v));
            end
            stall_q = ifc.out_valid && !ifc.out_ready;
            stall_v = {ifc.out_last, ifc.out_data};
            if (ifc.out_valid && ifc.out_ready) begin
                n_xfer++;
                if (ifc.out_last) n_last++;
                chk("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("elem", 32'({ifc.out_last, ifc.out_data}), 32'(sb.pop_front()));
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic push_exp(input int base, input int cnt);
        for (int w = 0; w < cnt; w++) begin
            int a;
            a = (base + w) % 1024;
            aq.push_back(AW'(a));
            for (int k = 0; k < NL; k++)
                sb.push_back({(w == cnt - 1) && (k == NL - 1), mem[a][k*DW +: DW]});
        end
    endtask

    task automatic pulse_start(input int base, input int cnt);
        @(posedge clk);
        #1;
        start_read = 1'b1;
        base_addr  = AW'(base);
        word_count = AW'(cnt);
        @(posedge clk);            // edge 0
        #1;
        start_read = 1'b0;
    endtask

    task automatic run_xfer(input int base, input int cnt, input bit repulse);
        int first_en, first_vld, done_c, last_c;
        first_en = -1; first_vld = -1; done_c = -1; last_c = -1;
        n_xfer = 0; n_last = 0; n_en = 0;
        push_exp(base, cnt);
        pulse_start(base, cnt);
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (ram_rd_en && first_en < 0) first_en = c;
            if (ifc.out_valid && first_vld < 0) first_vld = c;
            if (ifc.out_valid && ifc.out_ready) last_c = c;
            if (repulse && c == 6) begin
                start_read = 1'b1; base_addr = AW'(100); word_count = AW'(2);
            end
            if (repulse && c == 7) start_read = 1'b0;
            if (read_done) begin
                done_c = c;
                break;
            end
        end
        chk("done_seen", 32'(done_c > 0), 32'd1);
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_1cyc", 32'(read_done), 32'd0);
        if (cnt > 0) begin
            chk("first_en", 32'(first_en), 32'd1);
            chk("first_vld", 32'(first_vld), 32'(2 + LAT));
            chk("done_lat", 32'(done_c), 32'(last_c + 1));
            chk("n_last", 32'(n_last), 32'd1);
        end else begin
            chk("zero_done", 32'(done_c), 32'd1);
            chk("zero_vld", 32'(first_vld), 32'hFFFF_FFFF);
        end
        chk("n_xfer", 32'(n_xfer), 32'(NL * cnt));
        chk("n_en", 32'(n_en), 32'(cnt));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("aq_empty", 32'(aq.size()), 32'd0);
    endtask

    initial begin
        int k;
        for (int a = 0; a < 1024; a++)
            for (int j = 0; j < NL; j++)
                mem[a][j*DW +: DW] = (a == 5) ? DW'(16'h3C00 + j) : DW'(a * 9 + j + 16'h1000);
        en_p = '0;
        for (int i = 0; i < LAT; i++) a_p[i] = '0;
        rst = 1'b0;
        start_read = 1'b0;
        base_addr = '0;
        word_count = '0;
        ifc.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rden", 32'(ram_rd_en), 32'd0);
        chk("rst_done", 32'(read_done), 32'd0);
        chk("rst_last", 32'(ifc.out_last), 32'd0);
        rst = 1'b1;

        // Reset while element 4 of word 0 is presented.
        n_xfer = 0;
        push_exp(5, 1);
        pulse_start(5, 1);
        k = 0;
        for (int c = 0; c < 50 && k < 4; c++) begin
            @(negedge clk);
            if (ifc.out_valid && ifc.out_ready) k++;
        end
        chk("pre_rst_xfers", 32'(k), 32'd4);
        @(posedge clk);
        #2;
        chk("pre_rst_data", 32'(ifc.out_data), 32'h3C04);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rden", 32'(ram_rd_en), 32'd0);
        chk("mid_rst_done", 32'(read_done), 32'd0);
        sb.delete();
        aq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_xfer(5, 1, 1'b0);
        run_xfer(1022, 3, 1'b0);
        rdy_mode = 1'b1;
        run_xfer(7, 2, 1'b0);
        rdy_mode = 1'b0;
        run_xfer(0, 0, 1'b0);
        run_xfer(5, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
